// File: rtl/video_pkg.sv
// Shared video constants: TMDS control symbols, symbol width, colour expansion.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package video_pkg;

  localparam int TMDS_W = 10;

  // Control symbols indexed by {C1,C0}
  localparam logic [TMDS_W-1:0] TMDS_CTL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTL_11 = 10'b1010101011;

  // Replicate the nibble so 4'hF maps to full scale 8'hFF and 4'h0 to 8'h00.
  function automatic logic [7:0] expand4(input logic [3:0] n);
    return {n, n};
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One DVI TMDS channel: transition minimisation, then DC-balancing symbol selection.
// Latency: 2 clocks (input sampled at one edge drives q after the next edge).
// Backpressure: none; a new symbol is accepted and produced every clock.
module tmds_encoder
  import video_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        d,
  input  logic              c0,
  input  logic              c1,
  input  logic              de,
  output logic [TMDS_W-1:0] q
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Stage 1 state
  logic [8:0] qm_q, qm_d;
  logic       de_q, c0_q, c1_q;
  // Stage 2 state
  logic signed [5:0] cnt_q, cnt_d;
  logic [TMDS_W-1:0] q_q, q_d;

  logic [3:0] ones_in;
  logic       use_xnor;

  // Stage 1: choose XOR/XNOR chain to minimise transitions in the 8-bit word
  always_comb begin
    ones_in  = popcount8(d);
    use_xnor = (ones_in > 4'd4) || ((ones_in == 4'd4) && !d[0]);
    qm_d     = 9'd0;
    qm_d[0]  = d[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  logic [3:0]        n1, n0;
  logic signed [5:0] diff;
  logic signed [5:0] two_qm8;
  logic signed [5:0] two_nqm8;
  logic [TMDS_W-1:0] ctl_sym;

  // Stage 2: pick inverted or plain word to steer running disparity toward zero
  always_comb begin
    n1       = popcount8(qm_q[7:0]);
    n0       = 4'd8 - n1;
    diff     = $signed({2'b00, n1}) - $signed({2'b00, n0});
    two_qm8  = qm_q[8] ? 6'sd2 : 6'sd0;
    two_nqm8 = qm_q[8] ? 6'sd0 : 6'sd2;
    case ({c1_q, c0_q})
      2'b00:   ctl_sym = TMDS_CTL_00;
      2'b01:   ctl_sym = TMDS_CTL_01;
      2'b10:   ctl_sym = TMDS_CTL_10;
      default: ctl_sym = TMDS_CTL_11;
    endcase
    q_d   = ctl_sym;
    cnt_d = 6'sd0;
    if (de_q) begin
      if ((cnt_q == 6'sd0) || (n1 == n0)) begin
        q_d   = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
        cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 6'sd0) && (n1 > n0)) || ((cnt_q < 6'sd0) && (n0 > n1))) begin
        q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + two_qm8 - diff;
      end else begin
        q_d   = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - two_nqm8 + diff;
      end
    end
  end

  // Pipeline registers; reset drains to the idle control symbol with zero disparity
  always_ff @(posedge clk) begin
    if (!reset) begin
      qm_q  <= 9'd0;
      de_q  <= 1'b0;
      c0_q  <= 1'b0;
      c1_q  <= 1'b0;
      cnt_q <= 6'sd0;
      q_q   <= TMDS_CTL_00;
    end else begin
      qm_q  <= qm_d;
      de_q  <= de;
      c0_q  <= c0;
      c1_q  <= c1;
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/vga_to_tmds.sv
// VGA 12-bit RGB + sync to three DVI TMDS channel symbols (blue=ch0, green=ch1, red=ch2).
// Latency: 2 clocks, fixed.
// Backpressure: none; one pixel in and one symbol triple out every clock.
module vga_to_tmds
  import video_pkg::*;
#(
  parameter bit SYNC_INVERT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        vga_r,
  input  logic [3:0]        vga_g,
  input  logic [3:0]        vga_b,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic              vga_de,
  output logic [TMDS_W-1:0] tmds_r,
  output logic [TMDS_W-1:0] tmds_g,
  output logic [TMDS_W-1:0] tmds_b
);

  logic hs_enc, vs_enc;
  assign hs_enc = vga_hs ^ SYNC_INVERT;
  assign vs_enc = vga_vs ^ SYNC_INVERT;

  // Only the blue channel carries sync; red and green always send control code 00
  tmds_encoder u_enc_b (
    .clk(clk), .reset(reset), .d(expand4(vga_b)),
    .c0(hs_enc), .c1(vs_enc), .de(vga_de), .q(tmds_b)
  );

  tmds_encoder u_enc_g (
    .clk(clk), .reset(reset), .d(expand4(vga_g)),
    .c0(1'b0), .c1(1'b0), .de(vga_de), .q(tmds_g)
  );

  tmds_encoder u_enc_r (
    .clk(clk), .reset(reset), .d(expand4(vga_r)),
    .c0(1'b0), .c1(1'b0), .de(vga_de), .q(tmds_r)
  );

endmodule

// File: tb/tb_vga_to_tmds.sv
module tb_vga_to_tmds;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] vga_r = 4'd0, vga_g = 4'd0, vga_b = 4'd0;
  logic       vga_hs = 1'b0, vga_vs = 1'b0, vga_de = 1'b0;
  logic [9:0] tmds_r, tmds_g, tmds_b;

  always #5 clk = ~clk;

  vga_to_tmds dut (
    .clk(clk), .reset(reset),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- reference model (channel 0=b, 1=g, 2=r) ----------------
  function automatic logic [9:0] ctl_sym(input logic c1, input logic c0);
    case ({c1, c0})
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic void enc(input logic [7:0] d, input int cin,
                              output logic [9:0] sym, output int cout);
    int ones;
    bit use_xnor;
    int q8;
    logic [7:0] qm;
    int n1, n0;
    ones = $countones(d);
    use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q8 = use_xnor ? 0 : 1;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      sym  = (q8 == 1) ? {2'b01, qm} : {2'b10, ~qm};
      cout = cin + ((q8 == 1) ? (n1 - n0) : (n0 - n1));
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      sym  = {1'b1, (q8 == 1), ~qm};
      cout = cin + 2 * q8 + n0 - n1;
    end else begin
      sym  = {1'b0, (q8 == 1), qm};
      cout = cin - 2 * (1 - q8) + n1 - n0;
    end
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, o;
    w = s[9] ? ~s[7:0] : s[7:0];
    o[0] = w[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return o;
  endfunction

  int         m_cnt [3];
  logic [3:0] pend_n [3];
  logic       pend_de, pend_hs, pend_vs;
  logic [9:0] exp_sym [3];
  logic [3:0] exp_n [3];
  bit         exp_is_data = 1'b0;
  bit         model_ready = 1'b0;
  logic [9:0] m_s;
  int         m_co;

  // Model: one pending pixel in flight, then the encoded symbol is due on the output
  always @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 3; c++) begin
        exp_sym[c] = 10'h354;
        m_cnt[c]   = 0;
        pend_n[c]  = 4'd0;
      end
      pend_de = 1'b0; pend_hs = 1'b0; pend_vs = 1'b0;
      exp_is_data = 1'b0;
      model_ready = 1'b1;
    end else begin
      exp_is_data = pend_de;
      for (int c = 0; c < 3; c++) begin
        if (pend_de) begin
          enc({pend_n[c], pend_n[c]}, m_cnt[c], m_s, m_co);
          exp_sym[c] = m_s;
          m_cnt[c]   = m_co;
          exp_n[c]   = pend_n[c];
        end else begin
          m_cnt[c]   = 0;
          exp_sym[c] = (c == 0) ? ctl_sym(pend_vs, pend_hs) : 10'h354;
        end
      end
      pend_n[0] = vga_b; pend_n[1] = vga_g; pend_n[2] = vga_r;
      pend_de = vga_de; pend_hs = vga_hs; pend_vs = vga_vs;
    end
  end

  // Compare process: every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (model_ready) begin
      tests++;
      if ({tmds_r, tmds_g, tmds_b} !== {exp_sym[2], exp_sym[1], exp_sym[0]}) begin
        fails++;
        $display("FAIL symbols @%0t: got r=%h g=%h b=%h want r=%h g=%h b=%h", $time,
                 tmds_r, tmds_g, tmds_b, exp_sym[2], exp_sym[1], exp_sym[0]);
      end
      if (exp_is_data) begin
        tests++;
        if (decode(tmds_r) !== {exp_n[2], exp_n[2]} || decode(tmds_g) !== {exp_n[1], exp_n[1]} ||
            decode(tmds_b) !== {exp_n[0], exp_n[0]}) begin
          fails++;
          $display("FAIL decode @%0t: got r=%h g=%h b=%h want r=%h g=%h b=%h", $time,
                   decode(tmds_r), decode(tmds_g), decode(tmds_b), exp_n[2], exp_n[1], exp_n[0]);
        end
        for (int c = 0; c < 3; c++) begin
          tests++;
          if (m_cnt[c] > 10 || m_cnt[c] < -10) begin
            fails++;
            $display("FAIL cnt_bound ch%0d @%0t: got %0d want |cnt|<=10", c, $time, m_cnt[c]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic [3:0] r, g, b,
                       input logic hs, vs, de);
    @(negedge clk);
    reset = rst; vga_r = r; vga_g = g; vga_b = b;
    vga_hs = hs; vga_vs = vs; vga_de = de;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [9:0] got, input logic [9:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_cnt(input string name, input int want);
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (m_cnt[c] != want) begin
        fails++;
        $display("FAIL %s ch%0d: got %0d want %0d", name, c, m_cnt[c], want);
      end
    end
  endtask

  task automatic check_all(input string name, input logic [9:0] want);
    check_lit(name, tmds_r, want);
    check_lit(name, tmds_g, want);
    check_lit(name, tmds_b, want);
  endtask

  initial begin
    // 1. reset held for 3 clocks, then release in control period
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    hold(1);
    check_all("reset_out", 10'h354);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    hold(2);
    check_all("idle_after_release", 10'h354);
    check_cnt("cnt_after_release", 0);

    // 2. sync combinations on blue
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    hold(2);
    check_lit("hs_only_b", tmds_b, 10'h0AB);
    check_lit("hs_only_r", tmds_r, 10'h354);
    check_lit("hs_only_g", tmds_g, 10'h354);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    hold(2);
    check_lit("vs_only_b", tmds_b, 10'h154);
    check_lit("vs_only_r", tmds_r, 10'h354);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    hold(2);
    check_lit("hs_vs_b", tmds_b, 10'h2AB);
    check_lit("hs_vs_g", tmds_g, 10'h354);

    // 3. first active pixel after control: black then white
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    hold(2);
    check_all("black_first", 10'h100);
    check_cnt("black_cnt", -8);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    hold(2);
    check_all("white_first", 10'h200);
    check_cnt("white_cnt", -8);

    // 4. long white run, one control cycle, then black restarts from zero disparity
    for (int i = 0; i < 16; i++) drive(1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    hold(2);
    check_all("black_after_white_run", 10'h100);

    // 5/6. random lines with blanking; one-clock reset pulse mid-line
    for (int line = 0; line < 4; line++) begin
      for (int px = 0; px < 640; px++) begin
        if (line == 2 && px == 300) begin
          drive(1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                1'b1, 1'b1, 1'b1);
          hold(1);
          check_all("midline_reset", 10'h354);
        end
        drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
              1'b1, 1'b1, 1'b1);
      end
      for (int bl = 0; bl < 24; bl++) begin
        drive(1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
              1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      end
    end
    hold(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
